// File: rtl/pad_cfg_serializer.sv
// Serialises the 224-bit pad mux/config frame into the pad-ring shift chain whenever it changes.
// Define PAD_CFG_SERIALIZER_READBACK_EN to check the chain echo against the previously sent frame.
module pad_cfg_serializer #(
  parameter int HALF_PERIOD = 2
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic [31:0]  pad_mux_i,
  input  logic [191:0] pad_cfg_i,
  input  logic         force_i,
  input  logic         sdi_i,
  output logic         sclk_o,
  output logic         sdo_o,
  output logic         latch_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  localparam int         FRAME_W  = 224;
  localparam logic [7:0] DIV_MAX  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] LAST_BIT = 8'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  state_e             r_state;
  logic [7:0]         r_div;
  logic [7:0]         r_bit;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] r_shadow;
  logic               r_init_pending;
  logic               r_sclk;
  logic               r_sdo;
  logic               r_latch;
  logic               r_busy;
  logic               r_done;

  logic [FRAME_W-1:0] w_frame;
  logic               w_start;
  logic               w_tick;
  logic               w_load;
  logic               w_sclk_rise;
  logic               w_last;

  assign w_frame     = {pad_mux_i, pad_cfg_i};
  assign w_start     = (w_frame != r_shadow) || force_i || r_init_pending;
  assign w_tick      = (r_div == DIV_MAX);
  assign w_load      = (r_state == IDLE) && w_start;
  assign w_sclk_rise = (r_state == SHIFT) && w_tick && !r_sclk;
  assign w_last      = (r_state == SHIFT) && w_tick && r_sclk && (r_bit == LAST_BIT);

  // NOTE: all state here updates with <= so every flop sees the pre-edge values of the others.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state        <= IDLE;
      r_div          <= '0;
      r_bit          <= '0;
      r_shift        <= '0;
      r_shadow       <= '0;
      r_init_pending <= 1'b1;
      r_sclk         <= 1'b0;
      r_sdo          <= 1'b0;
      r_latch        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state        <= SHIFT;
            r_busy         <= 1'b1;
            r_shadow       <= w_frame;
            r_shift        <= {w_frame[FRAME_W-2:0], 1'b0};
            r_sdo          <= w_frame[FRAME_W-1];
            r_init_pending <= 1'b0;
            r_div          <= '0;
            r_bit          <= '0;
          end
        end
        SHIFT: begin
          r_div <= w_tick ? '0 : r_div + 8'd1;
          if (w_sclk_rise) begin
            r_sclk <= 1'b1;
          end else if (w_last) begin
            r_sclk  <= 1'b0;
            r_sdo   <= 1'b0;
            r_latch <= 1'b1;
            r_bit   <= '0;
            r_state <= LATCH;
          end else if (w_tick) begin
            // Falling edge of sclk_o: present the next bit while the chain holds the last one.
            r_sclk  <= 1'b0;
            r_bit   <= r_bit + 8'd1;
            r_sdo   <= r_shift[FRAME_W-1];
            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
          end
        end
        LATCH: begin
          r_div <= w_tick ? '0 : r_div + 8'd1;
          if (w_tick) begin
            r_latch <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sclk_o  = r_sclk;
  assign sdo_o   = r_sdo;
  assign latch_o = r_latch;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

`ifdef PAD_CFG_SERIALIZER_READBACK_EN
  logic [FRAME_W-1:0] r_rx;
  logic [FRAME_W-1:0] r_prev;
  logic               r_cmp_en;
  logic               r_err;

  // The chain echoes what it held before this frame, so compare against the shadow being replaced.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rx     <= '0;
      r_prev   <= '0;
      r_cmp_en <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_load) begin
        r_prev   <= r_shadow;
        r_cmp_en <= !r_init_pending;
      end
      if (w_sclk_rise) r_rx <= {r_rx[FRAME_W-2:0], sdi_i};
      if (w_last && r_cmp_en) r_err <= (r_rx != r_prev);
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_sdi;
  assign w_unused_sdi = sdi_i;
  assign err_o        = 1'b0;
`endif

endmodule

// File: doc/pad_cfg_serializer.md
PAD_CFG_SERIALIZER -- requirements
Module: pad_cfg_serializer

Interface
REQ-001 Parameter HALF_PERIOD, default 2, sets HCLK cycles per sclk_o half-period; legal range 1..255.
REQ-002 HCLK  input  1  clock; all logic is on the rising edge.
REQ-003 HRESETn  input  1  reset; asynchronous, active-low.
REQ-004 pad_mux_i  input  32  pad mux select from the APB pad/clock config register block.
REQ-005 pad_cfg_i  input  192  pad configuration, 32 pads x 6 bits, from the same block.
REQ-006 force_i  input  1  single-cycle request to resend the current configuration unconditionally.
REQ-007 sdi_i  input  1  serial return from the end of the pad-ring chain; used only when readback is compiled in.
REQ-008 sclk_o  output  1  pad-ring shift clock.
REQ-009 sdo_o  output  1  pad-ring serial data.
REQ-010 latch_o  output  1  pad-ring parallel-load strobe.
REQ-011 busy_o  output  1  high in any state other than IDLE.
REQ-012 done_o  output  1  one-cycle pulse when a frame completes.
REQ-013 err_o  output  1  sticky readback mismatch flag.

Function
REQ-014 Frame: 224 bits = {pad_mux_i, pad_cfg_i}, shifted MSB first, so pad_mux_i[31] goes first and pad_cfg_i[0] goes last.
REQ-015 State machine states: IDLE, SHIFT, LATCH.
REQ-016 Shadow register: holds the last frame sent.
REQ-017 IDLE -> SHIFT in the same cycle when any of these holds:
  - the current {pad_mux_i, pad_cfg_i} differs from the shadow;
  - force_i = 1;
  - init_pending = 1.
REQ-018 On the IDLE -> SHIFT edge, load the current inputs into both the shift register and the shadow, and clear init_pending.
REQ-019 SHIFT, per bit: sdo_o is valid with sclk_o low for HALF_PERIOD cycles, then sclk_o is high for HALF_PERIOD cycles; the chain samples on the sclk_o rising edge.
REQ-020 SHIFT, bit advance: sdo_o moves to the next bit on the same edge where sclk_o falls.
REQ-021 Bit counter: counts 0..223; when the high phase of bit 223 ends, sclk_o goes low and the FSM enters LATCH.
REQ-022 LATCH: latch_o is high for exactly HALF_PERIOD cycles, then the FSM returns to IDLE.
REQ-023 done_o: pulses high for one cycle, in the first IDLE cycle after LATCH.
REQ-024 Frame length: SHIFT lasts 448*HALF_PERIOD cycles and LATCH lasts HALF_PERIOD cycles.
REQ-025 Input changes and force_i during SHIFT or LATCH are not sampled.
REQ-026 After returning to IDLE the shadow compare is re-evaluated, so a pending difference starts the next frame on the first IDLE cycle; done_o still pulses in that cycle.
REQ-027 Back-to-back frames: no idle gap beyond that single IDLE cycle.
REQ-028 Outputs in IDLE: sclk_o = 0, latch_o = 0, sdo_o = 0.

Reset
REQ-029 On HRESETn low, asynchronously:
  - state = IDLE and shadow = 0;
  - sclk_o = 0, sdo_o = 0, latch_o = 0;
  - busy_o = 0, done_o = 0, err_o = 0;
  - counters = 0 and init_pending = 1.
REQ-030 First frame: starts in the first cycle after reset release, even if the inputs are all zero.
REQ-031 Reset in the middle of a frame aborts it immediately; no latch_o is issued for the aborted frame.

Configuration
REQ-032 Macro PAD_CFG_SERIALIZER_READBACK_EN controls readback checking.
REQ-033 With the macro defined: sample sdi_i on each sclk_o rising edge into a 224-bit receive register. The chain echoes its previous contents, so this register captures the frame sent before the current one.
REQ-034 With the macro defined, at LATCH entry compare the receive register with the previous shadow value. On mismatch, set err_o.
REQ-035 With the macro defined, skip the compare on the first frame after reset.
REQ-036 With the macro defined, err_o stays set until reset or until the next frame completes with a matching compare.
REQ-037 Without the macro, sdi_i is ignored, err_o is tied to 0, and no receive register or comparator is instantiated.

Verification
REQ-038 Reset release, inputs 0, HALF_PERIOD = 2 -> one frame of 224 rising edges of sdo_o = 0; busy_o high for 898 cycles; latch_o high for 2 cycles; done_o pulses once.
REQ-039 pad_mux_i = 32'hA5000001, pad_cfg_i = 0, in IDLE -> the first 32 sampled bits are 1010_0101_0000_0000_0000_0000_0000_0001; the next 192 bits are 0.
REQ-040 pad_cfg_i[5:0] changes from 0 to 6'h3F during SHIFT -> the current frame is unaffected; a second frame starts in the done_o cycle with its last 6 bits = 1.
REQ-041 force_i pulse in IDLE with unchanged inputs -> a full frame identical to the shadow is sent; force_i during SHIFT has no effect.
REQ-042 HRESETn asserted at bit 100 -> sclk_o = 0 and latch_o = 0 immediately; after release, a fresh 224-bit frame starts.
REQ-043 With the readback macro defined, a chain model that inverts one bit on the second frame -> err_o = 1 after that frame's LATCH entry; a third frame with a clean echo clears it.
